// File: rtl/pwm_sample_scheduler_pkg.sv
// pwm_sched_pkg: shared types and constants for the PWM sample scheduler.
//   state_t           scheduler FSM states
//   DEF_DATA_W/DIV_W  default sample and divider widths
//   CNT_W             underrun counter width
//   REQ_CPU/REQ_TONE  requester indices used by the round-robin arbiter
package pwm_sched_pkg;

  localparam int unsigned DEF_DATA_W = 12;
  localparam int unsigned DEF_DIV_W  = 16;
  localparam int unsigned CNT_W      = 16;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_TONE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_sample_scheduler_tick_gen.sv
// sample_tick_gen: sample-rate divider producing a one-cycle tick every
// cfg_div+1 cycles while enabled.
//   clk, rst_n  clock, async active-low reset
//   cfg_en      enable; while low the counter holds at cfg_div
//   cfg_div     period minus one
//   tick_c      combinational tick, high when counter is 0 and enabled
module sample_tick_gen
  import pwm_sched_pkg::*;
#(
  parameter int unsigned DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             tick_c
);

  logic [DIV_W-1:0] cnt;

  assign tick_c = cfg_en && (cnt == '0);

  // Down-counter: reload on tick, hold at cfg_div while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!cfg_en || (cnt == '0)) begin
      cnt <= cfg_div;
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/pwm_sample_scheduler.sv
// pwm_sample_scheduler: write-side controller for the PWM duty-cycle FIFO.
// Paces samples into the FIFO at the programmed rate, round-robin arbitrates
// between the CPU (req0) and tone generator (req1), and keeps underrun and
// missed-slot statistics.
//   clk, rst_n                 clock, async active-low reset
//   cfg_en, cfg_div            enable and sample period minus one
//   req0_* / req1_*            valid/data/ready requester handshakes
//   fifo_full                  FIFO write-side full flag
//   fifo_w_en, fifo_din        FIFO write strobe and data
//   underrun_cnt, slot_miss    saturating underrun count, sticky slot miss
//   stat_clr                   clears the statistics
// Optional feature: define SCHED_HOLD_LAST_EN to write the last sample again
// on an underrun instead of skipping the slot.
module pwm_sample_scheduler
  import pwm_sched_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DIV_W  = DEF_DIV_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              fifo_full,
  output logic              fifo_w_en,
  output logic [DATA_W-1:0] fifo_din,
  output logic [CNT_W-1:0]  underrun_cnt,
  output logic              slot_miss,
  input  logic              stat_clr
);

  state_t state;
  logic   tick_c;
  logic   rr_last;
  logic   gnt_idx_c;
  logic   underrun_c;
`ifdef SCHED_HOLD_LAST_EN
  logic [DATA_W-1:0] last_sample;
`endif

  sample_tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .cfg_en (cfg_en),
    .cfg_div(cfg_div),
    .tick_c (tick_c)
  );

  // Round-robin pick: when both are valid, favour the one not granted last
  always_comb begin
    gnt_idx_c = REQ_CPU;
    if (req0_valid && req1_valid) begin
      gnt_idx_c = ~rr_last;
    end else if (req1_valid) begin
      gnt_idx_c = REQ_TONE;
    end
  end

  assign underrun_c = (state == GRANT) && cfg_en && !fifo_full &&
                      !req0_valid && !req1_valid;

  // Slot FSM with registered write strobe, data and ready pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fifo_w_en  <= 1'b0;
      fifo_din   <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rr_last    <= REQ_TONE;
`ifdef SCHED_HOLD_LAST_EN
      last_sample <= '0;
`endif
    end else begin
      fifo_w_en  <= 1'b0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tick_c) state <= GRANT;
        end
        GRANT: begin
          if (!cfg_en) begin
            state <= IDLE;
          end else if (fifo_full) begin
            state <= GRANT;
          end else if (!req0_valid && !req1_valid) begin
`ifdef SCHED_HOLD_LAST_EN
            // Hold write: repeat last sample, arbitration pointer untouched
            state     <= WRITE;
            fifo_w_en <= 1'b1;
            fifo_din  <= last_sample;
`else
            state <= IDLE;
`endif
          end else begin
            state      <= WRITE;
            fifo_w_en  <= 1'b1;
            fifo_din   <= (gnt_idx_c == REQ_TONE) ? req1_data : req0_data;
            req0_ready <= (gnt_idx_c == REQ_CPU);
            req1_ready <= (gnt_idx_c == REQ_TONE);
            rr_last    <= gnt_idx_c;
          end
        end
        WRITE: begin
`ifdef SCHED_HOLD_LAST_EN
          last_sample <= fifo_din;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Statistics: clear has priority over increment and over sticky set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt <= '0;
      slot_miss    <= 1'b0;
    end else if (stat_clr) begin
      underrun_cnt <= '0;
      slot_miss    <= 1'b0;
    end else begin
      if (underrun_c && (underrun_cnt != '1)) begin
        underrun_cnt <= underrun_cnt + CNT_W'(1);
      end
      if (tick_c && (state != IDLE)) begin
        slot_miss <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// Directed bench for pwm_sample_scheduler: table of per-slot vectors plus
// hand-written sequences for stall, enable drop, reset-in-GRANT, short period.
module tb_pwm_sample_scheduler;

`ifdef SCHED_HOLD_LAST_EN
  localparam int HOLD = 1;
`else
  localparam int HOLD = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cfg_en;
  logic [15:0] cfg_div;
  logic        req0_valid;
  logic [11:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [11:0] req1_data;
  logic        req1_ready;
  logic        fifo_full;
  logic        fifo_w_en;
  logic [11:0] fifo_din;
  logic [15:0] underrun_cnt;
  logic        slot_miss;
  logic        stat_clr;

  pwm_sample_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_en      (cfg_en),
    .cfg_div     (cfg_div),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .fifo_full   (fifo_full),
    .fifo_w_en   (fifo_w_en),
    .fifo_din    (fifo_din),
    .underrun_cnt(underrun_cnt),
    .slot_miss   (slot_miss),
    .stat_clr    (stat_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r0v;
    logic [11:0] r0d;
    logic        r1v;
    logic [11:0] r1d;
    int          exp_wr;
    logic [11:0] exp_din;
    int          exp_r0;
    int          exp_r1;
    int          exp_unr;
  } vec_t;

  vec_t vecs[10];

  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int wr_cnt = 0;
  int r0_cnt = 0;
  int r1_cnt = 0;
  int last_wr_cyc = 0;
  logic [11:0] last_din = '0;
  logic prev_wen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Output monitor: counts writes/readies and checks pulse shape
  always @(negedge clk) begin
    cyc_cnt++;
    if (fifo_w_en) begin
      wr_cnt++;
      last_din = fifo_din;
      last_wr_cyc = cyc_cnt;
      chk("wen_pulse", 32'(prev_wen), 32'd0);
    end
    if (req0_ready) r0_cnt++;
    if (req1_ready) r1_cnt++;
    if (req0_ready || req1_ready) chk("rdy_align", 32'(fifo_w_en), 32'd1);
    prev_wen = fifo_w_en;
  end

  // One 10-cycle slot window starting in IDLE right after a write slot
  task automatic run_window(input vec_t v, input int idx);
    int s_wr, s_r0, s_r1, s_cyc;
    req0_valid = v.r0v;
    req0_data  = v.r0d;
    req1_valid = v.r1v;
    req1_data  = v.r1d;
    s_wr = wr_cnt; s_r0 = r0_cnt; s_r1 = r1_cnt; s_cyc = cyc_cnt;
    cyc(10);
    chk($sformatf("v%0d_writes", idx), 32'(wr_cnt - s_wr), 32'(v.exp_wr));
    if (v.exp_wr != 0) begin
      chk($sformatf("v%0d_din", idx), 32'(last_din), 32'(v.exp_din));
      chk($sformatf("v%0d_phase", idx), 32'(last_wr_cyc - s_cyc), 32'd9);
    end
    chk($sformatf("v%0d_rdy0", idx), 32'(r0_cnt - s_r0), 32'(v.exp_r0));
    chk($sformatf("v%0d_rdy1", idx), 32'(r1_cnt - s_r1), 32'(v.exp_r1));
    chk($sformatf("v%0d_unr", idx), 32'(underrun_cnt), 32'(v.exp_unr));
  endtask

  initial begin
    int s_wr, s_r0, s_r1;

    vecs[0] = '{1'b0, 12'h000, 1'b1, 12'h123, 1, 12'h123, 0, 1, 0};
    vecs[1] = '{1'b0, 12'h000, 1'b1, 12'h123, 1, 12'h123, 0, 1, 0};
    vecs[2] = '{1'b1, 12'h0AA, 1'b1, 12'h0BB, 1, 12'h0AA, 1, 0, 0};
    vecs[3] = '{1'b1, 12'h0AA, 1'b1, 12'h0BB, 1, 12'h0BB, 0, 1, 0};
    vecs[4] = '{1'b1, 12'h0AA, 1'b1, 12'h0BB, 1, 12'h0AA, 1, 0, 0};
    vecs[5] = '{1'b1, 12'h0AA, 1'b1, 12'h0BB, 1, 12'h0BB, 0, 1, 0};
    vecs[6] = '{1'b1, 12'h321, 1'b0, 12'h000, 1, 12'h321, 1, 0, 0};
    vecs[7] = '{1'b0, 12'h000, 1'b0, 12'h000, HOLD, 12'h321, 0, 0, 1};
    vecs[8] = '{1'b0, 12'h000, 1'b0, 12'h000, HOLD, 12'h321, 0, 0, 2};
    vecs[9] = '{1'b0, 12'h000, 1'b0, 12'h000, HOLD, 12'h321, 0, 0, 3};

    rst_n = 1'b0; cfg_en = 1'b0; cfg_div = 16'd9;
    req0_valid = 1'b0; req0_data = '0; req1_valid = 1'b0; req1_data = '0;
    fifo_full = 1'b0; stat_clr = 1'b0;
    cyc(2);
    chk("rst_wen", 32'(fifo_w_en), 32'd0);
    chk("rst_din", 32'(fifo_din), 32'd0);
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    chk("rst_rdy1", 32'(req1_ready), 32'd0);
    chk("rst_unr", 32'(underrun_cnt), 32'd0);
    chk("rst_miss", 32'(slot_miss), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Prime: first enabled slot writes 11 cycles after enable
    req1_valid = 1'b1; req1_data = 12'h123; cfg_en = 1'b1;
    s_wr = wr_cnt; s_r1 = r1_cnt;
    cyc(12);
    chk("prime_writes", 32'(wr_cnt - s_wr), 32'd1);
    chk("prime_din", 32'(last_din), 32'h123);
    chk("prime_rdy1", 32'(r1_cnt - s_r1), 32'd1);

    for (int i = 0; i < 10; i++) run_window(vecs[i], i);

    // FIFO stall across a tick: one late write, slot_miss set
    req0_valid = 1'b1; req0_data = 12'h5A5; req1_valid = 1'b0;
    s_wr = wr_cnt;
    cyc(7);
    fifo_full = 1'b1;
    cyc(15);
    fifo_full = 1'b0;
    chk("stall_nowr", 32'(wr_cnt - s_wr), 32'd0);
    chk("stall_miss", 32'(slot_miss), 32'd1);
    cyc(1);
    chk("stall_wen", 32'(fifo_w_en), 32'd1);
    chk("stall_din", 32'(fifo_din), 32'h5A5);
    chk("stall_rdy0", 32'(req0_ready), 32'd1);
    req0_valid = 1'b0; cfg_en = 1'b0; stat_clr = 1'b1;
    cyc(1);
    stat_clr = 1'b0;
    chk("clr_unr", 32'(underrun_cnt), 32'd0);
    chk("clr_miss", 32'(slot_miss), 32'd0);
    chk("stall_one_wr", 32'(wr_cnt - s_wr), 32'd1);

    // cfg_en dropped in a stalled GRANT: no write, divider held
    cfg_en = 1'b1; req0_valid = 1'b1; req0_data = 12'h777;
    s_wr = wr_cnt; s_r0 = r0_cnt;
    cyc(9);
    fifo_full = 1'b1;
    cyc(2);
    cfg_en = 1'b0;
    cyc(1);
    fifo_full = 1'b0;
    cyc(20);
    chk("endrop_nowr", 32'(wr_cnt - s_wr), 32'd0);
    chk("endrop_nordy", 32'(r0_cnt - s_r0), 32'd0);
    cfg_en = 1'b1;
    cyc(10);
    chk("hold_div_early", 32'(fifo_w_en), 32'd0);
    cyc(1);
    chk("hold_div_wen", 32'(fifo_w_en), 32'd1);
    chk("hold_div_din", 32'(fifo_din), 32'h777);
    chk("hold_div_rdy0", 32'(req0_ready), 32'd1);
    chk("hold_div_miss", 32'(slot_miss), 32'd0);
    req0_valid = 1'b0; cfg_en = 1'b0;
    cyc(1);

    // Reset during GRANT: aborts the slot, pointer back to req0
    req0_valid = 1'b1; req0_data = 12'h0AA;
    req1_valid = 1'b1; req1_data = 12'h0BB; cfg_en = 1'b1;
    cyc(10);
    s_wr = wr_cnt; s_r0 = r0_cnt; s_r1 = r1_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wen", 32'(fifo_w_en), 32'd0);
    chk("mid_rst_din", 32'(fifo_din), 32'd0);
    chk("mid_rst_rdy0", 32'(req0_ready), 32'd0);
    chk("mid_rst_rdy1", 32'(req1_ready), 32'd0);
    cfg_en = 1'b0;
    cyc(3);
    chk("mid_rst_nowr", 32'(wr_cnt - s_wr), 32'd0);
    chk("mid_rst_nordy", 32'((r0_cnt - s_r0) + (r1_cnt - s_r1)), 32'd0);
    rst_n = 1'b1;
    cyc(1);
    cfg_en = 1'b1;
    cyc(11);
    chk("post_rst_wen", 32'(fifo_w_en), 32'd1);
    chk("post_rst_din", 32'(fifo_din), 32'h0AA);
    chk("post_rst_rdy0", 32'(req0_ready), 32'd1);

    // Period shorter than a slot: slot_miss must set
    req0_valid = 1'b0; cfg_en = 1'b0; cfg_div = 16'd1;
    cyc(1);
    chk("short_miss_pre", 32'(slot_miss), 32'd0);
    cfg_en = 1'b1;
    cyc(10);
    chk("short_miss", 32'(slot_miss), 32'd1);
    cfg_en = 1'b0;
    cyc(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_sample_scheduler.md
# pwm_sample_scheduler

Write-side controller for the PWM duty-cycle async FIFO, in the CPU clock domain. It paces duty-cycle samples into the FIFO at a programmed sample rate and shares the single FIFO write port between two requesters: CPU MMIO writes and the tone-generator stream. It tracks underruns (no sample available in a slot) and missed slots (FIFO stalled across a tick). The PWM-domain reader drains the FIFO one sample at a time.

## Interface
- DATA_W, 12: duty-cycle sample width.
- DIV_W, 16: sample-period divider width.
- clk  in  1  CPU-domain clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_en  in  1  scheduler enable.
- cfg_div  in  DIV_W  sample period minus one, in clk cycles.
- req0_valid / req0_data / req0_ready  in / in DATA_W / out  CPU requester.
- req1_valid / req1_data / req1_ready  in / in DATA_W / out  tone-generator requester.
- fifo_full  in  1  async FIFO full flag, write side.
- fifo_w_en  out  1  FIFO write strobe.
- fifo_din  out  DATA_W  FIFO write data.
- underrun_cnt  out  16  count of slots with no valid requester; saturates at 0xFFFF.
- slot_miss  out  1  sticky; set when a tick arrives while a slot is still pending.
- stat_clr  in  1  clears underrun_cnt and slot_miss.

## Operation
- Tick generator:
  - Down-counter loads cfg_div; tick pulses when the counter is 0 and cfg_en=1, then the counter reloads.
  - Period is cfg_div+1 cycles. While cfg_en=0 the counter holds at cfg_div.
- FSM states:
  - IDLE: on tick, go to GRANT.
  - GRANT:
    - If cfg_en=0: return to IDLE with no write.
    - If fifo_full=1: stay in GRANT.
    - If neither requester is valid: underrun. Increment underrun_cnt, then go to WRITE with the hold sample if SCHED_HOLD_LAST_EN is defined, otherwise return to IDLE.
    - Otherwise, latch the grant and data, then go to WRITE.
  - WRITE: fifo_w_en=1, fifo_din=latched data; pulse the granted reqN_ready for this one cycle; update last_sample; go to IDLE.
- Arbitration:
  - Round-robin between the two requesters.
  - If both are valid, grant the one not granted last. If only one is valid, grant it.
  - The pointer updates only on a real grant; a hold write does not update it.
- A requester's valid/data must stay stable until its ready pulse. Ready is never asserted outside WRITE.
- A tick while in GRANT or WRITE sets slot_miss. That tick is dropped, not queued.
- stat_clr wins over a simultaneous increment: the counter becomes 0. It also wins over a simultaneous slot_miss set.

## Timing
- Reset values: fifo_w_en=0, fifo_din=0, req0_ready=0, req1_ready=0, underrun_cnt=0, slot_miss=0, state=IDLE, rr pointer favours req0, last_sample=0, divider=0.
- Latency:
  - Tick to GRANT: 1 cycle.
  - GRANT to WRITE when not full: 1 cycle.
  - So fifo_w_en asserts 2 cycles after the tick.
- Minimum slot cost is 3 cycles. With cfg_div<2, slot_miss sets.
- fifo_w_en is a single-cycle pulse and is never asserted while fifo_full was high in the preceding GRANT cycle.
- Reset assertion mid-slot aborts immediately: no write and no ready. A requester seen in GRANT but not yet served must retry.

## Configuration
- SCHED_HOLD_LAST_EN defined: an underrun writes last_sample, so the PWM keeps a steady output rate; underrun_cnt still increments.
- SCHED_HOLD_LAST_EN undefined: an underrun writes nothing and only increments underrun_cnt.

## Structure
- Package pwm_sched_pkg holds:
  - the state enum (IDLE, GRANT, WRITE);
  - default DATA_W and DIV_W constants;
  - the requester index constants REQ_CPU=0 and REQ_TONE=1.
- Sub-module sample_tick_gen contains the divider and emits tick. The arbiter and FSM stay in the top module.

## Test plan
- cfg_div=9, cfg_en=1, req1 always valid with 0x123 -> one fifo_w_en every 10 cycles with din=0x123; req1_ready pulses are aligned to fifo_w_en.
- Both requesters valid (req0=0x0AA, req1=0x0BB) for 4 slots -> din order 0x0AA, 0x0BB, 0x0AA, 0x0BB.
- fifo_full held for 15 cycles with cfg_div=9 -> write occurs 1 cycle after full drops; slot_miss=1; exactly one write for the stalled slot.
- No requester valid for 3 slots after a write of 0x321 -> underrun_cnt=3; with SCHED_HOLD_LAST_EN, 3 writes of 0x321; without it, 0 writes. stat_clr then gives underrun_cnt=0 and slot_miss=0.
- rst_n asserted in the GRANT cycle -> all outputs immediately take their reset values and no ready pulse occurs; after release, the first both-valid grant goes to req0.
- cfg_en dropped while in GRANT under fifo_full -> return to IDLE, no write, divider holds at cfg_div.
